// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the HD44780 character LCD driver:
//               controller/bus state encoding, command bytes, the power-on
//               initialisation table and cycle-count helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // One encoding shared by the init/cursor FSM (POWERUP, INIT, IDLE, WAIT)
    // and the bus sequencer (IDLE, SETUP, PULSE, HOLD, WAIT).
    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SETUP   = 3'd3,
        ST_PULSE   = 3'd4,
        ST_HOLD    = 3'd5,
        ST_WAIT    = 3'd6
    } lcd_state_t;

    localparam logic [7:0] c_FUNC_SET  = 8'h38;
    localparam logic [7:0] c_DISP_OFF  = 8'h08;
    localparam logic [7:0] c_CLEAR     = 8'h01;
    localparam logic [7:0] c_ENTRY     = 8'h06;
    localparam logic [7:0] c_DISP_ON   = 8'h0C;
    localparam logic [7:0] c_SET_DDRAM = 8'h80;

    localparam logic [7:0] c_ASCII_LF  = 8'h0A;
    localparam logic [7:0] c_ASCII_FF  = 8'h0C;

    localparam int unsigned c_CMD_US   = 40;
    localparam int unsigned c_CLR_US   = 1640;

    localparam int unsigned c_INIT_LEN = 8;

    // Power-on sequence; the first two function-set waits are the long
    // settling times the controller needs before it reliably latches.
    localparam logic [7:0] c_INIT_CMD [0:7] = '{
        c_FUNC_SET, c_FUNC_SET, c_FUNC_SET, c_FUNC_SET,
        c_DISP_OFF, c_CLEAR,    c_ENTRY,    c_DISP_ON
    };

    localparam int unsigned c_INIT_WAIT_US [0:7] = '{
        32'd4100, 32'd100, 32'd40, 32'd40,
        32'd40,   32'd1640, 32'd40, 32'd40
    };

    // Round up so the LCD never gets less than its minimum delay; never 0.
    function automatic longint unsigned us_to_cycles(
        input longint unsigned clk_hz,
        input longint unsigned us
    );
        longint unsigned cyc;
        cyc = (clk_hz * us + 64'd999_999) / 64'd1_000_000;
        return (cyc == 64'd0) ? 64'd1 : cyc;
    endfunction

    // E high/low phases must each last at least 250 ns.
    function automatic longint unsigned e_cycles(input longint unsigned clk_hz);
        longint unsigned cyc;
        cyc = (clk_hz + 64'd3_999_999) / 64'd4_000_000;
        return (cyc == 64'd0) ? 64'd1 : cyc;
    endfunction

    function automatic longint unsigned max_u64(
        input longint unsigned a,
        input longint unsigned b
    );
        return (a > b) ? a : b;
    endfunction

    // DDRAM address of column 0 for a given row.
    function automatic logic [7:0] ddram_base(
        input logic [1:0] row,
        input logic [7:0] cols
    );
        logic [7:0] base;
        case (row)
            2'd0:    base = 8'h00;
            2'd1:    base = 8'h40;
            2'd2:    base = cols;
            default: base = 8'h40 + cols;
        endcase
        return base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_cycle.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_cycle
// Description : One LCD bus transaction: SETUP (e=0), PULSE (e=1), HOLD (e=0),
//               each E_CYC cycles, then an execution WAIT of wait_len cycles.
//               data/rs are latched on start and held until the next start.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start           - begin a transaction (honoured when free)
//               cmd_byte/cmd_rs - byte and register select to drive
//               wait_len        - execution delay in cycles (>= 1)
//               data, rs, e     - registered LCD bus outputs
//               done            - high in the last WAIT cycle; a start in
//                                 that cycle chains the next transaction
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int unsigned E_CYC = 1,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    cmd_byte,
    input  logic          cmd_rs,
    input  logic [CW-1:0] wait_len,
    output logic [7:0]    data,
    output logic          rs,
    output logic          e,
    output logic          done
);

    localparam logic [CW-1:0] c_E_LAST = CW'(E_CYC - 1);

    lcd_state_t    r_phase;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_wait;
    logic [7:0]    r_data;
    logic          r_rs;
    logic          r_e;
    logic          w_free;

    assign done   = (r_phase == ST_WAIT) && (r_cnt == '0);
    assign w_free = (r_phase == ST_IDLE) || done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= ST_IDLE;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
            r_e     <= 1'b0;
        end else if (start && w_free) begin
            r_phase <= ST_SETUP;
            r_cnt   <= c_E_LAST;
            r_wait  <= wait_len;
            r_data  <= cmd_byte;
            r_rs    <= cmd_rs;
            r_e     <= 1'b0;
        end else begin
            case (r_phase)
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        r_phase <= ST_PULSE;
                        r_cnt   <= c_E_LAST;
                        r_e     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_PULSE: begin
                    if (r_cnt == '0) begin
                        r_phase <= ST_HOLD;
                        r_cnt   <= c_E_LAST;
                        r_e     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        r_phase <= ST_WAIT;
                        r_cnt   <= r_wait - CW'(1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_phase <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_IDLE: begin
                    r_e <= 1'b0;
                end
                default: begin
                    r_phase <= ST_IDLE;
                    r_e     <= 1'b0;
                end
            endcase
        end
    end

    assign data = r_data;
    assign rs   = r_rs;
    assign e    = r_e;

endmodule
`default_nettype wire

// File: rtl/lcd_controller.sv
`default_nettype none
// ============================================================================
// Module      : lcd_controller
// Description : HD44780-compatible character LCD driver. Runs the power-on
//               init sequence, then accepts ASCII bytes on a valid/ready
//               handshake, tracks the cursor and handles wrap, LF and FF.
// Ports       : clk        - system clock
//               reset      - synchronous active-high reset
//               ascii_data - byte to display or control code
//               write      - byte valid; accepted when write && ready
//               ready      - idle and able to accept a byte
//               data       - LCD DB7..DB0
//               rs         - 0 command, 1 data
//               rw         - tied low (busy flag never read)
//               e          - LCD enable strobe
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned POWERUP_US = 15000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_data,
    input  logic       write,
    output logic       ready,
    output logic [7:0] data,
    output logic       rs,
    output logic       rw,
    output logic       e
);

    localparam longint unsigned c_E_CYC    = e_cycles(64'(CLK_HZ));
    localparam longint unsigned c_PWR_CYC  = us_to_cycles(64'(CLK_HZ), 64'(POWERUP_US));
    localparam longint unsigned c_CMD_CYC  = us_to_cycles(64'(CLK_HZ), 64'(c_CMD_US));
    localparam longint unsigned c_CLR_CYC  = us_to_cycles(64'(CLK_HZ), 64'(c_CLR_US));
    localparam longint unsigned c_LONG_CYC = us_to_cycles(64'(CLK_HZ), 64'(c_INIT_WAIT_US[0]));
    localparam longint unsigned c_MAX_WAIT =
        max_u64(max_u64(c_PWR_CYC, c_LONG_CYC),
                max_u64(c_CLR_CYC, max_u64(c_CMD_CYC, c_E_CYC)));

    // Counters are loaded with (wait - 1), so $clog2 of the longest wait fits.
    localparam int unsigned c_CW = (c_MAX_WAIT <= 64'd1) ? 1 : $clog2(c_MAX_WAIT);

    localparam logic [c_CW-1:0] c_PWR_LOAD = c_CW'(c_PWR_CYC - 64'd1);
    localparam logic [c_CW-1:0] c_T_CMD    = c_CW'(c_CMD_CYC);
    localparam logic [c_CW-1:0] c_T_CLR    = c_CW'(c_CLR_CYC);
    localparam logic [1:0]      c_ROW_LAST = 2'(ROWS - 1);
    localparam logic [5:0]      c_COL_LAST = 6'(COLS - 1);
    localparam logic [7:0]      c_COLS_B   = 8'(COLS);

    logic [c_CW-1:0] w_init_wait [0:7];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_init_wait
            assign w_init_wait[gi] = c_CW'(us_to_cycles(64'(CLK_HZ), 64'(c_INIT_WAIT_US[gi])));
        end
    endgenerate

    lcd_state_t      r_state;
    logic [c_CW-1:0] r_pwr_cnt;
    logic [2:0]      r_init_idx;
    logic [1:0]      r_row;
    logic [5:0]      r_col;
    logic            r_ready;
    logic            r_pend;
    logic [7:0]      r_pend_cmd;

    logic            w_start;
    logic [7:0]      w_byte;
    logic            w_rs;
    logic [c_CW-1:0] w_wait;
    logic            w_bus_done;
    logic            w_accept;
    logic            w_printable;
    logic            w_wrap;
    logic [1:0]      w_next_row;
    logic [7:0]      w_next_addr;

    assign w_accept    = write && r_ready;
    assign w_printable = (ascii_data >= 8'h20) && (ascii_data <= 8'h7E);
    assign w_wrap      = (r_col == c_COL_LAST);
    assign w_next_row  = (r_row == c_ROW_LAST) ? 2'd0 : r_row + 2'd1;
    assign w_next_addr = c_SET_DDRAM | ddram_base(w_next_row, c_COLS_B);

    // The bus start is combinational so a transaction begins on the very
    // edge that accepts a byte or finishes the previous wait.
    always_comb begin
        w_start = 1'b0;
        w_byte  = 8'h00;
        w_rs    = 1'b0;
        w_wait  = c_T_CMD;
        case (r_state)
            ST_POWERUP: begin
                if (r_pwr_cnt == '0) begin
                    w_start = 1'b1;
                    w_byte  = c_INIT_CMD[0];
                    w_wait  = w_init_wait[0];
                end
            end
            ST_INIT: begin
                if (w_bus_done && (r_init_idx != 3'd7)) begin
                    w_start = 1'b1;
                    w_byte  = c_INIT_CMD[r_init_idx + 3'd1];
                    w_wait  = w_init_wait[r_init_idx + 3'd1];
                end
            end
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_printable) begin
                        w_start = 1'b1;
                        w_byte  = ascii_data;
                        w_rs    = 1'b1;
                    end else if (ascii_data == c_ASCII_LF) begin
                        w_start = 1'b1;
                        w_byte  = w_next_addr;
                    end else if (ascii_data == c_ASCII_FF) begin
                        w_start = 1'b1;
                        w_byte  = c_CLEAR;
                        w_wait  = c_T_CLR;
                    end
                end
            end
            ST_WAIT: begin
                if (w_bus_done && r_pend) begin
                    w_start = 1'b1;
                    w_byte  = r_pend_cmd;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_POWERUP;
            r_pwr_cnt  <= c_PWR_LOAD;
            r_init_idx <= 3'd0;
            r_row      <= 2'd0;
            r_col      <= 6'd0;
            r_ready    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_cmd <= 8'h00;
        end else begin
            case (r_state)
                ST_POWERUP: begin
                    if (r_pwr_cnt == '0) begin
                        r_state    <= ST_INIT;
                        r_init_idx <= 3'd0;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt - c_CW'(1);
                    end
                end
                ST_INIT: begin
                    if (w_bus_done) begin
                        if (r_init_idx == 3'd7) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            r_init_idx <= r_init_idx + 3'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_state <= ST_WAIT;
                            r_ready <= 1'b0;
                            if (w_wrap) begin
                                // Re-address the next row before ready returns.
                                r_col      <= 6'd0;
                                r_row      <= w_next_row;
                                r_pend     <= 1'b1;
                                r_pend_cmd <= w_next_addr;
                            end else begin
                                r_col <= r_col + 6'd1;
                            end
                        end else if (ascii_data == c_ASCII_LF) begin
                            r_state <= ST_WAIT;
                            r_ready <= 1'b0;
                            r_col   <= 6'd0;
                            r_row   <= w_next_row;
                        end else if (ascii_data == c_ASCII_FF) begin
                            r_state <= ST_WAIT;
                            r_ready <= 1'b0;
                            r_col   <= 6'd0;
                            r_row   <= 2'd0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_bus_done) begin
                        if (r_pend) begin
                            r_pend <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_POWERUP;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    lcd_bus_cycle #(
        .E_CYC (32'(c_E_CYC)),
        .CW    (c_CW)
    ) u_bus (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .cmd_byte (w_byte),
        .cmd_rs   (w_rs),
        .wait_len (w_wait),
        .data     (data),
        .rs       (rs),
        .e        (e),
        .done     (w_bus_done)
    );

    assign ready = r_ready;
    assign rw    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lcd_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_controller
// Description : Directed self-checking bench for lcd_controller at 1 MHz,
//               16x2, 10 us power-up (E_CYC=1, T_CMD=40, T_CLR=1640).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_controller;

    logic       clk;
    logic       reset;
    logic [7:0] ascii_data;
    logic       write;
    logic       ready;
    logic [7:0] data;
    logic       rs;
    logic       rw;
    logic       e;

    int checks = 0;
    int errors = 0;

    // Captured e pulses as {rs, data} and longest e-high run in cycles.
    logic [8:0] pq [$];
    int         hi_run = 0;
    int         hi_max = 0;
    logic       e_q = 1'b0;

    lcd_controller #(
        .CLK_HZ     (1_000_000),
        .COLS       (16),
        .ROWS       (2),
        .POWERUP_US (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ascii_data (ascii_data),
        .write      (write),
        .ready      (ready),
        .data       (data),
        .rs         (rs),
        .rw         (rw),
        .e          (e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (e === 1'b1 && e_q !== 1'b1) pq.push_back({rs, data});
        if (e === 1'b1) begin
            hi_run = hi_run + 1;
        end else if (e_q === 1'b1) begin
            if (hi_run > hi_max) hi_max = hi_run;
            hi_run = 0;
        end
        e_q = e;
    end

    function automatic logic [8:0] pq_at(input int i);
        return (i < pq.size()) ? pq[i] : 9'h1FF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, output int low);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        write      = 1'b1;
        ascii_data = b;
        @(negedge clk);
        write = 1'b0;
        low   = 0;
        while (ready !== 1'b1 && low < 5000) begin
            @(negedge clk);
            low++;
        end
    endtask

    task automatic run_init(input string tag);
        int   n;
        logic bad;
        logic [8:0] exp_init [0:7];
        exp_init = '{9'h038, 9'h038, 9'h038, 9'h038, 9'h008, 9'h001, 9'h006, 9'h00C};
        pq.delete();
        hi_max = 0;
        reset  = 1'b0;
        bad    = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (data !== 8'h00 || e !== 1'b0 || rs !== 1'b0 || ready !== 1'b0) bad = 1'b1;
        end
        chk({tag, "_quiet"}, {31'd0, bad}, 32'd0);
        @(negedge clk);
        chk({tag, "_setup"}, {22'd0, rs, data, e}, {22'd0, 1'b0, 8'h38, 1'b0});
        @(negedge clk);
        chk({tag, "_first_e"}, {31'd0, e}, 32'd1);
        n = 11;
        while (ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_cycles"}, n, 32'd6074);
        chk({tag, "_pulses"}, pq.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_cmd"}, {23'd0, pq_at(i)}, {23'd0, exp_init[i]});
        end
        chk({tag, "_e_width"}, hi_max, 32'd1);
    endtask

    initial begin
        int low;
        int n;
        logic bad;

        reset      = 1'b1;
        write      = 1'b0;
        ascii_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_data",  {24'd0, data}, 32'h00);
        chk("rst_rs",    {31'd0, rs},    32'd0);
        chk("rst_rw",    {31'd0, rw},    32'd0);
        chk("rst_e",     {31'd0, e},     32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);

        run_init("init");

        // Single printable character.
        pq.delete();
        send(8'h41, low);
        chk("char_low",   low, 32'd43);
        chk("char_count", pq.size(), 32'd1);
        chk("char_pulse", {23'd0, pq_at(0)}, {23'd0, 9'h141});

        // Characters 2..15 fill row 0 without wrapping.
        pq.delete();
        bad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            send(8'h61 + 8'(i), low);
            if (low != 43) bad = 1'b1;
        end
        chk("row_fill_low",   {31'd0, bad}, 32'd0);
        chk("row_fill_count", pq.size(), 32'd14);

        // 16th character wraps to row 1.
        pq.delete();
        send(8'h7A, low);
        chk("wrap_low",   low, 32'd86);
        chk("wrap_count", pq.size(), 32'd2);
        chk("wrap_char",  {23'd0, pq_at(0)}, {23'd0, 9'h17A});
        chk("wrap_addr",  {23'd0, pq_at(1)}, {23'd0, 9'h0C0});

        pq.delete();
        send(8'h42, low);
        chk("row1_low",  low, 32'd43);
        chk("row1_char", {23'd0, pq_at(0)}, {23'd0, 9'h142});

        // Newline from row 1 returns to row 0.
        pq.delete();
        send(8'h0A, low);
        chk("lf_low",  low, 32'd43);
        chk("lf_addr", {23'd0, pq_at(0)}, {23'd0, 9'h080});

        // Form feed clears.
        pq.delete();
        send(8'h0C, low);
        chk("ff_low",   low, 32'd1643);
        chk("ff_pulse", {23'd0, pq_at(0)}, {23'd0, 9'h001});

        // Unsupported control byte is dropped.
        pq.delete();
        send(8'h07, low);
        chk("drop_low", low, 32'd0);
        repeat (10) @(negedge clk);
        chk("drop_pulses", pq.size(), 32'd0);
        chk("drop_ready",  {31'd0, ready}, 32'd1);

        // Write held high across the busy window: only one byte taken.
        pq.delete();
        write      = 1'b1;
        ascii_data = 8'h43;
        @(negedge clk);
        n = 0;
        while (ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        write = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_low",    n, 32'd43);
        chk("hold_pulses", pq.size(), 32'd1);
        chk("hold_char",   {23'd0, pq_at(0)}, {23'd0, 9'h143});
        chk("char_e_width", hi_max, 32'd1);

        // Reset while e is high.
        write      = 1'b1;
        ascii_data = 8'h44;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        chk("mid_pulse_e", {31'd0, e}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_e",     {31'd0, e},     32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd0);
        chk("mid_rst_data",  {24'd0, data},  32'h00);
        repeat (2) @(negedge clk);

        run_init("replay");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
